pipe_stage_ctrl: RTL

Valid/stall/flush sequencer for the 32-bit four-stage register pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB). It generates one load enable per stage register and tracks per-stage valid bits. It applies back-pressure from the output and bubble insertion for hazards, and supports flush and drain/halt control. It sits beside the datapath registers and drives their enables; it never touches data.

---
 rtl/pipe_ctrl_pkg.sv | 15 +
 rtl/sat_counter.sv | 24 ++
 rtl/pipe_stage_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and parameter bounds for the pipeline stage controller.
// Holds the sequencer state enum and the legal ranges of the stage parameters.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam int STAGES_MIN    = 2;
  localparam int STAGES_MAX    = 8;
  localparam int HAZ_STAGE_MIN = 1;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc cycles and sticks at all ones.
// Latency: count reflects an inc on the following cycle. clear has priority over inc.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  // Count up until every bit is set, then hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_ctrl.sv
// Valid/stall/flush sequencer driving the load enables of a register pipeline.
// Latency: a word accepted at edge t reaches the last stage after edge t+STAGES-1.
// Backpressure: out_ready ripples combinationally back through the move chain to in_ready.
module pipe_stage_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STAGES    = 4,
  parameter int HAZ_STAGE = 1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              hazard,
  input  logic              flush,
  input  logic              drain_req,
  input  logic              resume,
  output logic [STAGES-1:0] stage_en,
  output logic [STAGES-1:0] stage_valid,
  output logic              drain_done,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  state_t            state;
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] mv;
  logic [STAGES-1:0] v_src;
  logic [STAGES-1:0] v_nxt;
  logic              hz_raw;
  logic              hz;
  logic              accept;
  logic              stall;

  // A hazard only matters when the stage feeding the bubble slot holds a word;
  // a flush wipes everything anyway, so it masks the hazard.
  assign hz_raw = hazard & v[HAZ_STAGE-1];
  assign hz     = hz_raw & ~flush;

  // A stage may move when it is empty or the stage after it moves
  always_comb begin
    mv = '0;
    mv[STAGES-1] = ~v[STAGES-1] | out_ready;
    for (int i = STAGES - 2; i >= 0; i--) begin
      mv[i] = ~v[i] | mv[i+1];
    end
  end

  assign in_ready = (state == RUN) & ~flush & ~hz & mv[0];
  assign accept   = in_valid & in_ready;

  // Each stage loads from the one before it; stage 0 loads the accepted input
  assign v_src = {v[STAGES-2:0], accept};

  // Enables and next valid bits, with flush over hazard over normal movement
  always_comb begin
    stage_en = '0;
    v_nxt    = v;
    for (int i = 0; i < STAGES; i++) begin
      if (flush) begin
        stage_en[i] = 1'b1;
        v_nxt[i]    = 1'b0;
      end else if (hz && (i < HAZ_STAGE)) begin
        stage_en[i] = 1'b0;
      end else begin
        stage_en[i] = mv[i];
        if (mv[i]) begin
          v_nxt[i] = (hz && (i == HAZ_STAGE)) ? 1'b0 : v_src[i];
        end
      end
    end
  end

  // Per-stage valid bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
    end else begin
      v <= v_nxt;
    end
  end

  // RUN/DRAIN/HALT sequencing; drain_done is a registered pulse on entry to HALT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      drain_done <= 1'b0;
    end else begin
      drain_done <= 1'b0;
      case (state)
        RUN: begin
          if (drain_req) state <= DRAIN;
        end
        DRAIN: begin
          if (v == '0) begin
            state      <= HALT;
            drain_done <= 1'b1;
          end
        end
        HALT: begin
          if (resume) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign stage_valid = v;
  assign out_valid   = v[STAGES-1];
  assign halted      = (state == HALT);

  // A flush cycle moves every stage, so it is never counted as a stall
  assign stall = ~flush & ((v[STAGES-1] & ~out_ready) | hz_raw);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall),
    .clear (1'b0),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush),
    .clear (1'b0),
    .count (flush_cnt)
  );

endmodule
